// File: rtl/ast_pkg.sv
// rtl/ast_pkg.sv - shared types for the Avalon-ST packet sanitizer
package ast_pkg;
  localparam int AST_DATA_W    = 64;
  localparam int AST_EMPTY_W   = 3;
  localparam int AST_ERROR_W   = 1;
  localparam int AST_CHANNEL_W = 8;
  localparam int AST_TUSER_W   = 1;
  localparam int TRUNC_ERR_BIT = 0;

  typedef struct packed {
    logic [AST_DATA_W-1:0]    data;
    logic                     sop;
    logic                     eop;
    logic [AST_EMPTY_W-1:0]   empty;
    logic [AST_ERROR_W-1:0]   error;
    logic [AST_CHANNEL_W-1:0] channel;
    logic [AST_TUSER_W-1:0]   tuser;
  } st_word_t;

  typedef enum logic {IDLE, IN_PKT} fsm_t;
endpackage

// File: rtl/ast_sat_cnt.sv
// rtl/ast_sat_cnt.sv - saturating event counter
module ast_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/ast_pkt_sanitizer.sv
// rtl/ast_pkt_sanitizer.sv - repairs sop/eop framing with a one-word hold-back buffer
module ast_pkt_sanitizer
  import ast_pkg::*;
#(
  parameter int DATA_W    = AST_DATA_W,
  parameter int EMPTY_W   = AST_EMPTY_W,
  parameter int ERROR_W   = AST_ERROR_W,
  parameter int CHANNEL_W = AST_CHANNEL_W,
  parameter int TUSER_W   = AST_TUSER_W,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    snk_data,
  input  logic                 snk_sop,
  input  logic                 snk_eop,
  input  logic                 snk_val,
  input  logic [EMPTY_W-1:0]   snk_empty,
  input  logic [ERROR_W-1:0]   snk_error,
  input  logic [CHANNEL_W-1:0] snk_channel,
  input  logic [TUSER_W-1:0]   snk_tuser,
  output logic                 snk_ready,
  output logic [DATA_W-1:0]    src_data,
  output logic                 src_sop,
  output logic                 src_eop,
  output logic                 src_val,
  output logic [EMPTY_W-1:0]   src_empty,
  output logic [ERROR_W-1:0]   src_error,
  output logic [CHANNEL_W-1:0] src_channel,
  output logic [TUSER_W-1:0]   src_tuser,
  input  logic                 src_ready,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     trunc_cnt
);
  fsm_t     st_q;
  st_word_t hold_q, src_q, in_w, rel_w;
  logic     hold_val_q, src_val_q;
  logic     out_free, release_ok, accept, trunc, orphan, load_hold, do_release;

  always_comb begin
    in_w         = '0;
    in_w.data    = snk_data;
    in_w.sop     = snk_sop;
    in_w.eop     = snk_eop;
    in_w.empty   = snk_empty;
    in_w.error   = snk_error;
    in_w.channel = snk_channel;
    in_w.tuser   = snk_tuser;
  end

  // A non-eop word may only leave hold together with its successor.
  assign out_free   = !src_val_q || src_ready;
  assign release_ok = out_free && (hold_q.eop || (snk_val && st_q == IN_PKT));
  assign snk_ready  = rst_n && (!hold_val_q || release_ok);
  assign accept     = snk_val && snk_ready;
  assign trunc      = accept && snk_sop && (st_q == IN_PKT);
  assign orphan     = accept && !snk_sop && (st_q == IDLE);
  assign load_hold  = accept && !orphan;
  assign do_release = hold_val_q && release_ok;

  always_comb begin
    rel_w = hold_q;
    if (trunc) begin
      rel_w.eop                  = 1'b1;
      rel_w.empty                = '0;
      rel_w.error[TRUNC_ERR_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      hold_val_q <= 1'b0;
      hold_q     <= '0;
      src_val_q  <= 1'b0;
      src_q      <= '0;
    end else begin
      if (accept) begin
        case (st_q)
          IDLE:    if (snk_sop) st_q <= snk_eop ? IDLE : IN_PKT;
          IN_PKT:  st_q <= snk_eop ? IDLE : IN_PKT;
          default: st_q <= IDLE;
        endcase
      end
      if (load_hold) begin
        hold_q     <= in_w;
        hold_val_q <= 1'b1;
      end else if (do_release) begin
        hold_val_q <= 1'b0;
      end
      if (do_release) begin
        src_q     <= rel_w;
        src_val_q <= 1'b1;
      end else if (src_ready) begin
        src_val_q <= 1'b0;
      end
    end
  end

  assign src_val     = src_val_q;
  assign src_data    = src_q.data;
  assign src_sop     = src_q.sop;
  assign src_eop     = src_q.eop;
  assign src_empty   = src_q.empty;
  assign src_error   = src_q.error;
  assign src_channel = src_q.channel;
  assign src_tuser   = src_q.tuser;

  ast_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (orphan),
    .cnt_o (drop_cnt)
  );

  ast_sat_cnt #(.CNT_W(CNT_W)) u_trunc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (trunc),
    .cnt_o (trunc_cnt)
  );
endmodule

// File: tb/tb_ast_pkt_sanitizer.sv
// tb/tb_ast_pkt_sanitizer.sv - randomized bench with a framing reference model
module tb_ast_pkt_sanitizer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] snk_data;
  logic        snk_sop, snk_eop, snk_val, snk_ready;
  logic [2:0]  snk_empty;
  logic [0:0]  snk_error;
  logic [7:0]  snk_channel;
  logic [0:0]  snk_tuser;
  logic [63:0] src_data;
  logic        src_sop, src_eop, src_val, src_ready;
  logic [2:0]  src_empty;
  logic [0:0]  src_error;
  logic [7:0]  src_channel;
  logic [0:0]  src_tuser;
  logic [31:0] drop_cnt, trunc_cnt;

  typedef struct packed {
    logic [63:0] d;
    logic        s;
    logic        e;
    logic [2:0]  em;
    logic [0:0]  er;
    logic [7:0]  ch;
    logic [0:0]  tu;
  } w_t;

  w_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  bit in_pkt = 0;
  int m_drop = 0, m_trunc = 0;
  int cyc = 0, acc_eop_cyc = 0, out_eop_cyc = 0, out_cnt = 0, rdy_drop = 0;
  int rdy_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ast_pkt_sanitizer dut (
    .clk(clk), .rst_n(rst_n),
    .snk_data(snk_data), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_val(snk_val),
    .snk_empty(snk_empty), .snk_error(snk_error), .snk_channel(snk_channel),
    .snk_tuser(snk_tuser), .snk_ready(snk_ready),
    .src_data(src_data), .src_sop(src_sop), .src_eop(src_eop), .src_val(src_val),
    .src_empty(src_empty), .src_error(src_error), .src_channel(src_channel),
    .src_tuser(src_tuser), .src_ready(src_ready),
    .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output side compares against the model queue; input side feeds the model.
  always @(negedge clk) begin
    w_t o, n, t;
    if (rst_n) begin
      if (src_val) begin
        o = {src_data, src_sop, src_eop, src_empty, src_error, src_channel, src_tuser};
        if (exp_q.size() == 0) begin
          check("unexpected_out", 128'(1), 128'(0));
        end else begin
          check("out_word", 128'(o), 128'(exp_q[0]));
          if (src_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
            if (src_eop) out_eop_cyc = cyc;
          end
        end
      end
      if (snk_val && !snk_ready) rdy_drop++;
      if (snk_val && snk_ready) begin
        if (snk_eop) acc_eop_cyc = cyc;
        n = {snk_data, snk_sop, snk_eop, snk_empty, snk_error, snk_channel, snk_tuser};
        if (in_pkt || snk_sop) begin
          if (in_pkt && snk_sop && exp_q.size() > 0) begin
            t = exp_q.pop_back();
            t.e  = 1'b1;
            t.em = 3'd0;
            t.er = 1'b1;
            exp_q.push_back(t);
            m_trunc++;
          end
          exp_q.push_back(n);
          in_pkt = !snk_eop;
        end else begin
          m_drop++;
        end
      end
    end
  end

  initial begin
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = !src_ready;
        2:       src_ready = ($urandom_range(0, 3) != 0);
        default: src_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [63:0] d, input logic s, input logic e);
    int  n = 0;
    bit  ok = 0;
    snk_data    = d;
    snk_sop     = s;
    snk_eop     = e;
    snk_empty   = 3'($urandom);
    snk_error   = 1'($urandom);
    snk_channel = 8'($urandom);
    snk_tuser   = 1'($urandom);
    snk_val     = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = snk_ready;
      n++;
      if (!ok) @(posedge clk);
    end
    if (!ok) check("send_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    snk_val = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    snk_val  = 1'b0;
    rdy_mode = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    snk_val = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; snk_data = '0;
    snk_empty = '0; snk_error = '0; snk_channel = '0; snk_tuser = '0;
    #1;
    check("rst_src_val", 128'(src_val), 128'(0));
    check("rst_snk_ready", 128'(snk_ready), 128'(0));
    check("rst_src_data", 128'(src_data), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    base = out_cnt;
    send(64'd1, 1, 0); send(64'd2, 0, 0); send(64'd3, 0, 1);
    drain("t1_drain");
    check("t1_count", 128'(out_cnt - base), 128'(3));
    check("t1_eop_latency", 128'(out_eop_cyc - acc_eop_cyc), 128'(2));
    check("t1_drop", 128'(drop_cnt), 128'(0));
    check("t1_trunc", 128'(trunc_cnt), 128'(0));

    send(64'hAA, 0, 0); send(64'h10, 1, 0); send(64'h11, 0, 1);
    drain("t2_drain");
    check("t2_drop", 128'(drop_cnt), 128'(1));

    send(64'hA1, 1, 0); send(64'hA2, 0, 0); send(64'hB1, 1, 0); send(64'hB2, 0, 1);
    drain("t3_drain");
    check("t3_trunc", 128'(trunc_cnt), 128'(1));

    base = out_cnt;
    rdy_drop = 0;
    for (int i = 0; i < 16; i++) send(64'(i + 32'h100), 1, 1);
    drain("t4_drain");
    check("t4_count", 128'(out_cnt - base), 128'(16));
    check("t4_ready_drop", 128'(rdy_drop), 128'(0));

    base = out_cnt;
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) send(64'(i + 32'h200), i == 0, i == 9);
    drain("t5_drain");
    check("t5_count", 128'(out_cnt - base), 128'(10));

    rdy_mode = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      send({$urandom, $urandom}, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
    end
    send(64'hF1F1, 1, 1);
    drain("t6_drain");
    check("t6_drop", 128'(drop_cnt), 128'(m_drop));
    check("t6_trunc", 128'(trunc_cnt), 128'(m_trunc));

    rdy_mode = 3;
    send(64'h77, 1, 0); send(64'h78, 0, 0);
    idle(2);
    check("t7_pre_src_val", 128'(src_val), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_src_val", 128'(src_val), 128'(0));
    check("t7_snk_ready", 128'(snk_ready), 128'(0));
    check("t7_drop", 128'(drop_cnt), 128'(0));
    check("t7_trunc", 128'(trunc_cnt), 128'(0));
    exp_q.delete();
    in_pkt = 0; m_drop = 0; m_trunc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(1);
    base = out_cnt;
    send(64'h31, 1, 0); send(64'h32, 0, 0); send(64'h33, 0, 1);
    drain("t7_drain");
    check("t7_count", 128'(out_cnt - base), 128'(3));
    check("t7_post_drop", 128'(drop_cnt), 128'(0));
    check("t7_post_trunc", 128'(trunc_cnt), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
